// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO, one bit per cycle.
// Signed MULT/DIV are enabled by defining MD_SIGNED_EN; otherwise they run unsigned.
module mult_div_unit #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] R_TYPE_OP  = 3'b111
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic [2:0]            alu_op_i,
  input  logic [5:0]            alu_function_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic [DATA_WIDTH-1:0] rt_data_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic [DATA_WIDTH-1:0] md_result_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic is_r, dec_mfhi, dec_mthi, dec_mflo, dec_mtlo, dec_mul, dec_div, md_op;
  logic rt_zero, start, dbz_start;

  always_comb begin
    is_r      = valid_i && (alu_op_i == R_TYPE_OP);
    dec_mfhi  = is_r && (alu_function_i == 6'h10);
    dec_mthi  = is_r && (alu_function_i == 6'h11);
    dec_mflo  = is_r && (alu_function_i == 6'h12);
    dec_mtlo  = is_r && (alu_function_i == 6'h13);
    dec_mul   = is_r && ((alu_function_i == 6'h18) || (alu_function_i == 6'h19));
    dec_div   = is_r && ((alu_function_i == 6'h1A) || (alu_function_i == 6'h1B));
    md_op     = dec_mfhi || dec_mthi || dec_mflo || dec_mtlo || dec_mul || dec_div;
    rt_zero   = (rt_data_i == '0);
    start     = (state == IDLE) && !flush_i && (dec_mul || (dec_div && !rt_zero));
    dbz_start = (state == IDLE) && !flush_i && dec_div && rt_zero;
  end

  logic [W-1:0]   a_mag, b_mag;
  logic [W-1:0]   hi, lo, opnd;
  logic [2*W-1:0] acc;
  logic [W:0]     rem;
  logic [CW-1:0]  cnt;
  logic           is_div, dbz;

`ifdef MD_SIGNED_EN
  logic op_signed, a_neg, b_neg, neg_res, neg_rem;
  assign op_signed = (alu_function_i == 6'h18) || (alu_function_i == 6'h1A);
  assign a_neg     = op_signed && rs_data_i[W-1];
  assign b_neg     = op_signed && rt_data_i[W-1];
  assign a_mag     = a_neg ? -rs_data_i : rs_data_i;
  assign b_mag     = b_neg ? -rt_data_i : rt_data_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (start) begin
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
    end
  end
`else
  assign a_mag = rs_data_i;
  assign b_mag = rt_data_i;
`endif

  // Multiply: {upper, multiplier} shifts right, multiplicand added on lsb.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nx;
  // Divide: dividend shifts out of acc[W-1:0] while quotient bits shift in.
  logic [W+1:0]   rem_sh, diff;
  logic           q_bit;
  logic [W:0]     rem_nx;

  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nx  = {mul_sum, acc[W-1:1]};
    rem_sh  = {rem, acc[W-1]};
    diff    = rem_sh - {2'b00, opnd};
    q_bit   = ~diff[W+1];
    rem_nx  = q_bit ? diff[W:0] : rem_sh[W:0];
  end

  logic [2*W-1:0] prod;
  logic [W-1:0]   quot, remv;

  always_comb begin
    prod = acc;
    quot = acc[W-1:0];
    remv = rem[W-1:0];
`ifdef MD_SIGNED_EN
    if (neg_res) begin
      prod = -acc;
      quot = -acc[W-1:0];
    end
    if (neg_rem) remv = -rem[W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (flush_i) state_nx = IDLE;
               else if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state != IDLE);
    stall_o       = busy_o && md_op;
    div_by_zero_o = dbz;
    hi_o          = hi;
    lo_o          = lo;
    md_result_o   = '0;
    if (dec_mfhi)      md_result_o = hi;
    else if (dec_mflo) md_result_o = lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      acc    <= '0;
      rem    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      dbz <= dbz_start;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= dec_div;
            cnt    <= '0;
            rem    <= '0;
            opnd   <= dec_div ? b_mag : a_mag;
            acc    <= {{W{1'b0}}, (dec_div ? a_mag : b_mag)};
          end
          if (!flush_i && dec_mthi) hi <= rs_data_i;
          if (!flush_i && dec_mtlo) lo <= rs_data_i;
        end
        RUN: if (!flush_i) begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= {acc[2*W-1:W], acc[W-2:0], q_bit};
            rem <= rem_nx;
          end else begin
            acc <= mul_nx;
          end
        end
        DONE: if (!flush_i) begin
          if (is_div) begin
            lo <= quot;
            hi <= remv;
          end else begin
            hi <= prod[2*W-1:W];
            lo <= prod[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table, hand-written corner sequences, random ops vs. model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, valid, flush;
  logic [2:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] rs, rt;
  logic         stall, busy, dbz;
  logic [W-1:0] md_result, hi, lo;

  mult_div_unit #(.DATA_WIDTH(W), .R_TYPE_OP(3'b111)) dut (
    .clk(clk), .reset(reset), .valid_i(valid), .alu_op_i(alu_op),
    .alu_function_i(funct), .rs_data_i(rs), .rt_data_i(rt), .flush_i(flush),
    .stall_o(stall), .busy_o(busy), .md_result_o(md_result),
    .div_by_zero_o(dbz), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [W-1:0] hi_m, lo_m;

  typedef struct {
    string        name;
    logic [5:0]   f;
    logic [W-1:0] a, b, eh, el;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain 64-bit arithmetic reference; HI/LO unchanged on divide by zero.
  function automatic void model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                inout logic [W-1:0] h, inout logic [W-1:0] l);
    logic signed [63:0] sa, sb, q, r, p;
    logic sgn;
`ifdef MD_SIGNED_EN
    sgn = (f == 6'h18) || (f == 6'h1A);
`else
    sgn = 1'b0;
`endif
    sa = sgn ? {{32{a[W-1]}}, a} : {32'b0, a};
    sb = sgn ? {{32{b[W-1]}}, b} : {32'b0, b};
    if (f == 6'h18 || f == 6'h19) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (b != 0) begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end
  endfunction

  task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int   n;
    logic zdiv;
    zdiv  = (f == 6'h1A || f == 6'h1B) && (b == 0);
    valid = 1'b1; alu_op = 3'b111; funct = f; rs = a; rt = b;
    @(posedge clk); @(negedge clk);
    valid = 1'b0; funct = 6'h00;
    chk({name, " dbz"}, 64'(dbz), 64'(zdiv));
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk({name, " busy_cycles"}, 64'(n), zdiv ? 64'd0 : 64'(W + 1));
    if (zdiv) begin
      @(negedge clk);
      chk({name, " dbz_pulse_end"}, 64'(dbz), 64'd0);
    end
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
    hi_m = eh; lo_m = el;
  endtask

  task automatic mt(input logic [5:0] f, input logic [W-1:0] val);
    valid = 1'b1; alu_op = 3'b111; funct = f; rs = val;
    @(negedge clk);
    valid = 1'b0; funct = 6'h00;
    if (f == 6'h11) hi_m = val; else lo_m = val;
  endtask

  vec_t v;
  initial begin
    int n;
    logic [5:0] ops [4] = '{6'h18, 6'h19, 6'h1A, 6'h1B};
    logic [5:0] f;
    logic [W-1:0] a, b, eh, el;

    reset = 1'b1; valid = 1'b0; flush = 1'b0; alu_op = 3'b000; funct = 6'h00;
    rs = '0; rt = '0;
    hi_m = '0; lo_m = '0;
    @(negedge clk); @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset dbz", 64'(dbz), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    v = '{"multu_max",  6'h19, 32'hFFFFFFFF, 32'h2,        32'h1,        32'hFFFFFFFE}; vecs.push_back(v);
    v = '{"multu_sq",   6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001}; vecs.push_back(v);
    v = '{"multu_zero", 6'h19, 32'h12345678, 32'h0,        32'h0,        32'h0};        vecs.push_back(v);
    v = '{"divu_100_7", 6'h1B, 32'd100,      32'd7,        32'd2,        32'd14};       vecs.push_back(v);
    v = '{"divu_small", 6'h1B, 32'd5,        32'd7,        32'd5,        32'd0};        vecs.push_back(v);
    v = '{"divu_max",   6'h1B, 32'hFFFFFFFF, 32'h1,        32'h0,        32'hFFFFFFFF}; vecs.push_back(v);
`ifdef MD_SIGNED_EN
    v = '{"mult_m3x5",  6'h18, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1}; vecs.push_back(v);
    v = '{"mult_m1m1",  6'h18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1};        vecs.push_back(v);
    v = '{"div_m7_2",   6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD}; vecs.push_back(v);
    v = '{"div_7_m2",   6'h1A, 32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD}; vecs.push_back(v);
    v = '{"div_minint", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000}; vecs.push_back(v);
`else
    v = '{"mult_as_u",  6'h18, 32'hFFFFFFFD, 32'd5,        32'h4,        32'hFFFFFFF1}; vecs.push_back(v);
    v = '{"div_as_u",   6'h1A, 32'hFFFFFFF9, 32'd2,        32'h1,        32'h7FFFFFFC}; vecs.push_back(v);
`endif
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);

    // MT writes, then divide by zero must leave them alone
    mt(6'h11, 32'h11);
    mt(6'h13, 32'h22);
    chk("mthi", 64'(hi), 64'h11);
    chk("mtlo", 64'(lo), 64'h22);
    run_op("divu_by_zero", 6'h1B, 32'd5, 32'd0, 32'h11, 32'h22);

    // MFLO arrives 3 cycles into DIVU 100/7 and stalls until the result lands
    valid = 1'b1; alu_op = 3'b111; funct = 6'h1B; rs = 32'd100; rt = 32'd7;
    @(posedge clk); @(negedge clk);
    valid = 1'b0; funct = 6'h00;
    @(negedge clk); @(negedge clk);
    valid = 1'b1; funct = 6'h12; #1;
    n = 0;
    while (stall && n < 100) begin n++; @(negedge clk); #1; end
    chk("mflo stall_cycles", 64'(n), 64'd31);
    chk("mflo result", 64'(md_result), 64'd14);
    funct = 6'h10; #1;
    chk("mfhi result", 64'(md_result), 64'd2);
    valid = 1'b0; funct = 6'h00;
    hi_m = 32'd2; lo_m = 32'd14;
    @(negedge clk);

    // Flush in IDLE drops an MTHI
    flush = 1'b1;
    mt(6'h11, 32'hDEAD);
    flush = 1'b0;
    hi_m = 32'd2;
    chk("flush_idle mthi", 64'(hi), 64'd2);

    // Flush on RUN cycle 10 aborts without touching HI/LO
    mt(6'h11, 32'hAAAA);
    mt(6'h13, 32'h5555);
    valid = 1'b1; alu_op = 3'b111; funct = 6'h19; rs = 32'hFFFFFFFF; rt = 32'hFFFFFFFF;
    @(posedge clk); @(negedge clk);
    valid = 1'b0; funct = 6'h00;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush hi", 64'(hi), 64'hAAAA);
    chk("flush lo", 64'(lo), 64'h5555);
    run_op("multu_6x7", 6'h19, 32'd6, 32'd7, 32'd0, 32'd42);

    // Randomised ops against the model
    for (int i = 0; i < 30; i++) begin
      f = ops[$urandom_range(0, 3)];
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      eh = hi_m; el = lo_m;
      model(f, a, b, eh, el);
      run_op($sformatf("rand%0d_f%0h", i, f), f, a, b, eh, el);
    end

    // Asynchronous reset in the middle of a multiply with MFLO stalled behind it
    run_op("multu_pre", 6'h19, 32'd9, 32'd7, 32'd0, 32'd63);
    valid = 1'b1; alu_op = 3'b111; funct = 6'h19; rs = 32'd3; rt = 32'd4;
    @(posedge clk); @(negedge clk);
    funct = 6'h12;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_reset stall", 64'(stall), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset busy", 64'(busy), 64'd0);
    chk("async_reset stall", 64'(stall), 64'd0);
    chk("async_reset hi", 64'(hi), 64'd0);
    chk("async_reset lo", 64'(lo), 64'd0);
    valid = 1'b0; funct = 6'h00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
